// File: rtl/operative_ctrl.sv
// Sequencing FSM for the 16-bit operative datapath (X/S/H registers, m0/m1/m2 muxes, add/mul ULA).
// Outputs are registered Moore decodes of the state being entered, so they line up with the state register.
module operative_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       done,
  output logic       load_x,
  output logic       load_s,
  output logic       load_h,
  output logic       H,
  output logic [1:0] sel_m0,
  output logic [1:0] sel_m1,
  output logic [1:0] sel_m2
);

  localparam int unsigned ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = 4'd0,
    S_LDX  = 4'd1,
    S_MUL1 = 4'd2,
    S_ADD1 = 4'd3,
    S_MUL2 = 4'd4,
    S_ADD2 = 4'd5,
    S_ACC  = 4'd6,
    S_SCL  = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] mode_q;
  logic [1:0] nxt_mode;

  logic       d_busy, d_done, d_load_x, d_load_s, d_load_h, d_h;
  logic [1:0] d_m0, d_m1, d_m2;

  // Next-state: start/mode only matter in IDLE; unused encodings fall back to IDLE.
  always_comb begin
    nxt      = state;
    nxt_mode = mode_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt      = S_LDX;
          nxt_mode = mode;
        end
      end
      S_LDX:  nxt = (mode_q == 2'd3) ? S_SCL : S_MUL1;
      S_MUL1: nxt = (mode_q == 2'd2) ? S_ACC : S_ADD1;
      S_ADD1: nxt = (mode_q == 2'd0) ? S_MUL2 : S_DONE;
      S_MUL2: nxt = S_ADD2;
      S_ADD2: nxt = S_DONE;
      S_ACC:  nxt = S_DONE;
      S_SCL:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Output decode of the state about to be entered; MUL1 always parks A*X in Hreg for the following add.
  always_comb begin
    d_busy   = 1'b0;
    d_done   = 1'b0;
    d_load_x = 1'b0;
    d_load_s = 1'b0;
    d_load_h = 1'b0;
    d_h      = 1'b0;
    d_m0     = 2'd0;
    d_m1     = 2'd0;
    d_m2     = 2'd0;
    case (nxt)
      S_LDX: begin
        d_busy   = 1'b1;
        d_load_x = 1'b1;
      end
      S_MUL1: begin
        d_busy   = 1'b1;
        d_h      = 1'b1;
        d_load_h = 1'b1;
      end
      S_ADD1: begin
        d_busy   = 1'b1;
        d_m0     = 2'd1;
        d_m1     = 2'd3;
        d_m2     = 2'd1;
        d_load_h = (nxt_mode == 2'd0);
        d_load_s = (nxt_mode == 2'd1);
      end
      S_MUL2: begin
        d_busy   = 1'b1;
        d_h      = 1'b1;
        d_m1     = 2'd3;
        d_load_h = 1'b1;
      end
      S_ADD2: begin
        d_busy   = 1'b1;
        d_m0     = 2'd2;
        d_m1     = 2'd3;
        d_m2     = 2'd1;
        d_load_s = 1'b1;
      end
      S_ACC: begin
        d_busy   = 1'b1;
        d_m1     = 2'd2;
        d_m2     = 2'd3;
        d_load_s = 1'b1;
      end
      S_SCL: begin
        d_busy   = 1'b1;
        d_h      = 1'b1;
        d_m1     = 2'd2;
        d_load_s = 1'b1;
      end
      S_DONE: d_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_q <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      load_x <= 1'b0;
      load_s <= 1'b0;
      load_h <= 1'b0;
      H      <= 1'b0;
      sel_m0 <= 2'd0;
      sel_m1 <= 2'd0;
      sel_m2 <= 2'd0;
    end else begin
      state  <= nxt;
      mode_q <= nxt_mode;
      busy   <= d_busy;
      done   <= d_done;
      load_x <= d_load_x;
      load_s <= d_load_s;
      load_h <= d_load_h;
      H      <= d_h;
      sel_m0 <= d_m0;
      sel_m1 <= d_m1;
      sel_m2 <= d_m2;
    end
  end

endmodule

// File: tb/tb_operative_ctrl.sv
// Bench for operative_ctrl: behavioural datapath (A=2,B=3,C=5,X=4) plus a scoreboard of
// expected per-cycle control vectors and final S results, popped by an independent monitor.
module tb_operative_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic       busy, done, load_x, load_s, load_h, H;
  logic [1:0] sel_m0, sel_m1, sel_m2;

  operative_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .load_x(load_x), .load_s(load_s), .load_h(load_h),
    .H(H), .sel_m0(sel_m0), .sel_m1(sel_m1), .sel_m2(sel_m2)
  );

  always #5 clk = ~clk;

  // Datapath model
  localparam logic [15:0] A_V = 16'd2, B_V = 16'd3, C_V = 16'd5, X_V = 16'd4;
  logic [15:0] x_r = 16'd0, s_r = 16'd0, h_r = 16'd0;
  logic [15:0] m0, m1, m2, ula;

  always_comb begin
    case (sel_m0)
      2'd0: m0 = A_V;
      2'd1: m0 = B_V;
      2'd2: m0 = C_V;
      default: m0 = 16'd0;
    endcase
    case (sel_m1)
      2'd0: m1 = m0;
      2'd1: m1 = x_r;
      2'd2: m1 = s_r;
      default: m1 = h_r;
    endcase
    case (sel_m2)
      2'd0: m2 = x_r;
      2'd1: m2 = m0;
      2'd2: m2 = s_r;
      default: m2 = h_r;
    endcase
    ula = H ? 16'(m1 * m2) : 16'(m1 + m2);
  end

  always @(posedge clk) begin
    if (load_x) x_r <= X_V;
    if (load_s) s_r <= ula;
    if (load_h) h_r <= ula;
  end

  // Expected vectors {busy,done,load_x,load_s,load_h,H,sel_m0,sel_m1,sel_m2}
  localparam logic [11:0] V_IDLE   = 12'b0;
  localparam logic [11:0] V_LDX    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0};
  localparam logic [11:0] V_MUL1   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0};
  localparam logic [11:0] V_ADD1_H = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 2'd1};
  localparam logic [11:0] V_ADD1_S = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 2'd1};
  localparam logic [11:0] V_MUL2   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0};
  localparam logic [11:0] V_ADD2   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd3, 2'd1};
  localparam logic [11:0] V_ACC    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd3};
  localparam logic [11:0] V_SCL    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0};
  localparam logic [11:0] V_DONE   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0};

  logic [11:0] act_vec;
  assign act_vec = {busy, done, load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2};

  logic [11:0] vec_q[$];
  logic [15:0] res_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_seq(input logic [1:0] m, input logic [15:0] res);
    vec_q.push_back(V_LDX);
    case (m)
      2'd0: begin
        vec_q.push_back(V_MUL1); vec_q.push_back(V_ADD1_H);
        vec_q.push_back(V_MUL2); vec_q.push_back(V_ADD2);
      end
      2'd1: begin vec_q.push_back(V_MUL1); vec_q.push_back(V_ADD1_S); end
      2'd2: begin vec_q.push_back(V_MUL1); vec_q.push_back(V_ACC); end
      default: vec_q.push_back(V_SCL);
    endcase
    vec_q.push_back(V_DONE);
    res_q.push_back(res);
  endtask

  // Monitor: compares every active cycle (and the cycle after DONE when a relaunch is queued)
  logic        prev_done = 1'b0;
  logic [11:0] exp_vec;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy || done || prev_done) begin
        if (vec_q.size() != 0) begin
          exp_vec = vec_q.pop_front();
          chk("ctrl_vec", 32'(act_vec), 32'(exp_vec));
        end else if (busy || done) begin
          chk("unexpected_activity", 32'(act_vec), 32'(V_IDLE));
        end
      end
      if (done) begin
        if (res_q.size() != 0) chk("result_s", 32'(s_r), 32'(res_q.pop_front()));
        else chk("unexpected_done", 32'(done), 32'd0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic launch(input logic [1:0] m, input logic [15:0] res);
    push_seq(m, res);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk(name, 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(act_vec), 32'(V_IDLE));
    rst_n = 1'b1;

    // Reset asserted mid-MUL2 of a mode 0 run
    push_seq(2'd0, 16'd49);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("in_mul2_before_reset", 32'(act_vec), 32'(V_MUL2));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(act_vec), 32'(V_IDLE));
    vec_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    chk("held_reset_outputs", 32'(act_vec), 32'(V_IDLE));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    launch(2'd0, 16'd49);   // (2*4+3)*4+5
    wait_done("timeout_mode0");
    repeat (2) @(posedge clk);

    launch(2'd1, 16'd11);   // 2*4+3
    wait_done("timeout_mode1");
    repeat (2) @(posedge clk);

    launch(2'd2, 16'd19);   // 11+8
    wait_done("timeout_mode2a");
    repeat (2) @(posedge clk);

    launch(2'd3, 16'd76);   // 19*4
    wait_done("timeout_mode3");
    repeat (2) @(posedge clk);

    // Mode 2 again with start/mode disturbed while busy and during DONE
    launch(2'd2, 16'd84);   // 76+8
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 2'd1;
    wait_done("timeout_mode2b");
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);

    // Start held high: two mode 3 runs separated by exactly one IDLE cycle
    push_seq(2'd3, 16'd336);
    vec_q.push_back(V_IDLE);
    push_seq(2'd3, 16'd1344);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'd3;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    chk("vec_queue_drained", 32'(vec_q.size()), 32'd0);
    chk("res_queue_drained", 32'(res_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
